// File: rtl/spi_buffer_sync.sv
// spi_buffer_sync: oversampled SPI target, all four modes, with flat rx/tx byte
// arrays, a per-transaction length and done/overrun status.
module spi_buffer_sync #(
   parameter int MAX_BYTES = 4,
   parameter bit CPOL      = 1'b0,
   parameter bit CPHA      = 1'b0,
   parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   spi_sclk,
   input  logic                   spi_cs_n,
   input  logic                   spi_rx,
   output logic                   spi_tx,
   input  logic [MAX_BYTES*8-1:0] tx_data,
   input  logic [LEN_W-1:0]       length,
   output logic [MAX_BYTES*8-1:0] rx_data,
   output logic [LEN_W-1:0]       byte_count,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun
);
   localparam logic [1:0] IDLE = 2'd0, SELECT = 2'd1, XFER = 2'd2;
   logic [2:0] sclk_q, cs_q;
   logic [1:0] rx_q;
   logic [1:0] state_q, state_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] rsh_q, rsh_d, tsh_q, tsh_d, tx_byte, byte_in;
   logic tx_q, tx_d, busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
   logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
   logic [MAX_BYTES*8-1:0] rxd_q, rxd_d;
   logic [LEN_W:0] nxt;
   logic lead, trail, cs_fall, cs_rise, active, smp, shf, cmp;
   assign lead    = (sclk_q[2] == CPOL) && (sclk_q[1] != CPOL);
   assign trail   = (sclk_q[2] != CPOL) && (sclk_q[1] == CPOL);
   assign cs_fall = cs_q[2] & ~cs_q[1];
   assign cs_rise = ~cs_q[2] & cs_q[1];
   assign active  = state_q != IDLE;
   assign smp     = active && (CPHA ? trail : lead);
   assign shf     = active && (CPHA ? lead : trail);
   assign cmp     = smp && bit_q == 3'd7;
   assign byte_in = {rsh_q[6:0], rx_q[1]};
   assign nxt     = {1'b0, cnt_q} + 1'b1;
   always_comb begin
      tx_byte = 8'h00;
      for (int i = 0; i < MAX_BYTES; i++)
         if (nxt == (LEN_W+1)'(i) && nxt < {1'b0, len_q}) tx_byte = tx_data[8*i +: 8];
   end
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      rsh_d   = rsh_q;
      tsh_d   = tsh_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ovr_d   = ovr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      rxd_d   = rxd_q;
      if (cs_rise) begin
         state_d = IDLE;
         busy_d  = 1'b0;
      end else if (cs_fall) begin
         state_d = SELECT;
         len_d   = (length > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : length;
         cnt_d   = '0;
         ovr_d   = 1'b0;
         bit_d   = 3'd0;
         busy_d  = 1'b1;
         // CPHA=0 must present the MSB before the first edge; CPHA=1 waits for it
         tsh_d   = CPHA ? tx_data[7:0] : {tx_data[6:0], 1'b0};
         tx_d    = CPHA ? tx_q : tx_data[7];
      end else begin
         state_d = (state_q == SELECT) ? XFER : state_q;
         if (smp) begin
            rsh_d = byte_in;
            bit_d = bit_q + 3'd1;
         end
         if (shf) begin
            tx_d  = tsh_q[7];
            tsh_d = {tsh_q[6:0], 1'b0};
         end
         if (cmp) begin
            for (int i = 0; i < MAX_BYTES; i++)
               if (cnt_q == LEN_W'(i) && cnt_q < len_q) rxd_d[8*i +: 8] = byte_in;
            ovr_d  = ovr_q | (cnt_q >= len_q);
            cnt_d  = &cnt_q ? cnt_q : cnt_q + LEN_W'(1);
            tsh_d  = tx_byte;
            done_d = nxt == {1'b0, len_q};
         end
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_q  <= {3{CPOL}};
         cs_q    <= 3'b000;
         rx_q    <= 2'b00;
         state_q <= IDLE;
         bit_q   <= 3'd0;
         rsh_q   <= 8'h00;
         tsh_q   <= 8'h00;
         tx_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
         rxd_q   <= '0;
      end else begin
         sclk_q  <= {sclk_q[1:0], spi_sclk};
         cs_q    <= {cs_q[1:0], spi_cs_n};
         rx_q    <= {rx_q[0], spi_rx};
         state_q <= state_d;
         bit_q   <= bit_d;
         rsh_q   <= rsh_d;
         tsh_q   <= tsh_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         rxd_q   <= rxd_d;
      end
   end
   assign spi_tx     = tx_q;
   assign rx_data    = rxd_q;
   assign byte_count = cnt_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overrun    = ovr_q;
endmodule

// File: tb/tb_spi_buffer_sync.sv
// tb_spi_buffer_sync: drives all four SPI modes in parallel from one controller
// model and checks rx array, MISO stream, count and status against vector tables.
module tb_spi_buffer_sync;
   localparam int MB = 4;
   localparam int LW = $clog2(MB + 1);
   localparam int H  = 80;
   typedef struct {
      logic [LW-1:0] len;
      int            n;
      logic [39:0]   mosi;
      logic [31:0]   tx;
      logic [31:0]   rx;
      logic [LW-1:0] cnt;
      logic          ovr;
      int            dn;
      logic [39:0]   miso;
   } vec_t;
   vec_t v [6];
   logic clk = 1'b0, reset_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi0 = 1'b0, mosi1 = 1'b0;
   logic [MB*8-1:0] tx_data = '0;
   logic [LW-1:0] length = '0;
   logic [3:0] miso, busy, done, overrun;
   logic [MB*8-1:0] rx_data [4];
   logic [LW-1:0] byte_count [4];
   int done_cnt [4] = '{default: 0};
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : m
         spi_buffer_sync #(.MAX_BYTES(MB), .CPOL(1'(g / 2)), .CPHA(1'(g % 2))) dut (
            .clk(clk), .reset_n(reset_n),
            .spi_sclk((g / 2 == 1) ? ~sclk : sclk), .spi_cs_n(cs_n),
            .spi_rx((g % 2 == 1) ? mosi1 : mosi0), .spi_tx(miso[g]),
            .tx_data(tx_data), .length(length), .rx_data(rx_data[g]),
            .byte_count(byte_count[g]), .busy(busy[g]), .done(done[g]), .overrun(overrun[g]));
      end
   endgenerate
   always @(posedge clk)
      for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   // one controller drives both phase variants: mosi0 for CPHA=0, mosi1 for CPHA=1
   task automatic xfer_bits(input logic [7:0] b, input int nb, output logic [3:0][7:0] got);
      got = '0;
      for (int i = 7; i > 7 - nb; i--) begin
         mosi0 = b[i];
         #H;
         got[0][i] = miso[0];
         got[2][i] = miso[2];
         sclk  = 1'b1;
         mosi1 = b[i];
         #H;
         got[1][i] = miso[1];
         got[3][i] = miso[3];
         sclk = 1'b0;
      end
   endtask
   task automatic check_all(input string tag, input logic [31:0] rx, input logic [LW-1:0] cnt,
                            input logic ovr, input int dn, input int d0 [4]);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s m%0d rx_data", tag, i), rx_data[i], rx);
         chk($sformatf("%s m%0d byte_count", tag, i), 32'(byte_count[i]), 32'(cnt));
         chk($sformatf("%s m%0d overrun", tag, i), 32'(overrun[i]), 32'(ovr));
         chk($sformatf("%s m%0d done_pulses", tag, i), done_cnt[i] - d0[i], dn);
         chk($sformatf("%s m%0d busy", tag, i), 32'(busy[i]), 32'd1);
      end
   endtask
   task automatic run_vec(input vec_t x, input string tag);
      logic [3:0][7:0] got;
      int d0 [4];
      for (int i = 0; i < 4; i++) d0[i] = done_cnt[i];
      length  = x.len;
      tx_data = x.tx;
      cs_n    = 1'b0;
      for (int k = 0; k < x.n; k++) begin
         xfer_bits(x.mosi[8*k +: 8], 8, got);
         for (int i = 0; i < 4; i++)
            chk($sformatf("%s m%0d miso byte%0d", tag, i, k), 32'(got[i]), 32'(x.miso[8*k +: 8]));
      end
      #H;
      check_all(tag, x.rx, x.cnt, x.ovr, x.dn, d0);
      cs_n = 1'b1;
      #40;
   endtask
   initial begin
      logic [3:0][7:0] got;
      int d0 [4];
      v[0] = '{3'd4, 4, 40'h00_04030201, 32'hA1B2C3D4, 32'h04030201, 3'd4, 1'b0, 1, 40'h00_A1B2C3D4};
      v[1] = '{3'd1, 1, 40'h5A, 32'hDEADBEEF, 32'h0403025A, 3'd1, 1'b0, 1, 40'hEF};
      v[2] = '{3'd2, 5, 40'hEE_DDCCBBAA, 32'h11223344, 32'h0403BBAA, 3'd5, 1'b1, 1, 40'h00_00003344};
      v[3] = '{3'd1, 2, 40'h8877, 32'h000000C1, 32'h0403BB77, 3'd2, 1'b1, 1, 40'h00C1};
      v[4] = '{3'd0, 1, 40'h99, 32'h000000C5, 32'h0403BB77, 3'd1, 1'b1, 0, 40'hC5};
      v[5] = '{3'd7, 5, 40'h50_40302010, 32'h55667788, 32'h40302010, 3'd5, 1'b1, 1, 40'h00_55667788};
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset m%0d rx_data", i), rx_data[i], 32'h0);
         chk($sformatf("reset m%0d byte_count", i), 32'(byte_count[i]), 32'h0);
         chk($sformatf("reset m%0d status", i), {busy[i], done[i], overrun[i], miso[i]}, 32'h0);
      end
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      for (int t = 0; t < 6; t++) begin
         run_vec(v[t], $sformatf("v%0d", t));
         for (int i = 0; i < 4; i++) chk($sformatf("v%0d m%0d busy_after_cs", t, i), 32'(busy[i]), 32'h0);
      end
      // chip select released three bits into byte 1
      for (int i = 0; i < 4; i++) d0[i] = done_cnt[i];
      length  = 3'd2;
      tx_data = 32'h0;
      cs_n    = 1'b0;
      xfer_bits(8'h55, 8, got);
      xfer_bits(8'hAA, 3, got);
      #H;
      check_all("abort", 32'h40302055, 3'd1, 1'b0, 0, d0);
      cs_n = 1'b1;
      #80;
      for (int i = 0; i < 4; i++) chk($sformatf("abort m%0d busy_after_cs", i), 32'(busy[i]), 32'h0);
      // reset pulsed in the middle of byte 2
      length  = 3'd4;
      tx_data = 32'hA1B2C3D4;
      cs_n    = 1'b0;
      xfer_bits(8'h11, 8, got);
      xfer_bits(8'h22, 8, got);
      xfer_bits(8'h33, 3, got);
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("midrst m%0d rx_data", i), rx_data[i], 32'h0);
         chk($sformatf("midrst m%0d byte_count", i), 32'(byte_count[i]), 32'h0);
         chk($sformatf("midrst m%0d status", i), {busy[i], done[i], overrun[i], miso[i]}, 32'h0);
      end
      #29;
      reset_n = 1'b1;
      #40;
      cs_n = 1'b1;
      #40;
      run_vec(v[0], "after_rst");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
